// File: rtl/subcore_dispatcher_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_package
// Purpose  : Shared definitions for the subcore dispatcher slice: subcore
//            count and the dispatcher state enumeration.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package inst_package;

    // Number of subcores attached to the main core.
    localparam int SUBCORE_NUM = 8;

    // Dispatcher control states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2
    } dispatch_state_t;

endpackage : inst_package
`default_nettype wire

// File: rtl/subcore_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module   : subcore_dispatcher_if
// Purpose  : Fork/join command and subcore handshake bundle between the main
//            core, the dispatcher and the subcore array.
// Ports    : master - main-core / subcore-array side (drives fork command and
//                     end pulses, observes launches and join status)
//            slave  - dispatcher side
// Revision : 1.0 - initial release
// ============================================================================
interface subcore_dispatcher_if
    import inst_package::*;
#(
    parameter int N = SUBCORE_NUM
);
    logic               fork_valid;
    logic               fork_ready;
    logic [31:0]        fork_pc;
    logic [N-1:0]       fork_mask;
    logic               subcore_ended  [N];
    logic               exec_requested [N];
    logic [31:0]        requested_pc   [N];
    logic [N-1:0]       busy_mask;
    logic               join_done;
    logic               join_timeout;
    logic               spurious_end;

    modport master (
        output fork_valid, fork_pc, fork_mask, subcore_ended,
        input  fork_ready, exec_requested, requested_pc, busy_mask,
               join_done, join_timeout, spurious_end
    );

    modport slave (
        input  fork_valid, fork_pc, fork_mask, subcore_ended,
        output fork_ready, exec_requested, requested_pc, busy_mask,
               join_done, join_timeout, spurious_end
    );
endinterface : subcore_dispatcher_if
`default_nettype wire

// File: rtl/subcore_dispatcher_timer.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_timer
// Purpose  : Counts cycles spent in RUN and flags expiry on the cycle whose
//            count equals TIMEOUT_CYCLES-1. Used only when
//            SUBCORE_DISPATCH_TIMEOUT_EN is defined.
// Ports    : clk       - clock
//            rstn      - asynchronous active-low reset
//            i_run     - dispatcher is in RUN this cycle
//            o_expired - this RUN cycle is the last one allowed
// Revision : 1.0 - initial release
// ============================================================================
module dispatch_timer #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  wire logic clk,
    input  wire logic rstn,
    input  wire logic i_run,
    output logic      o_expired
);
    localparam logic [31:0] c_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] r_cnt;

    // Held at zero outside RUN, so it is already cleared on RUN entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= r_cnt + 32'd1;
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_expired = i_run && (r_cnt == c_LAST);

endmodule : dispatch_timer
`default_nettype wire

// File: rtl/subcore_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : subcore_dispatcher
// Purpose  : Fork/join controller. Accepts a fork (PC + subcore mask), pulses
//            exec_requested for one cycle to each selected subcore, tracks
//            the running set and pulses join_done when it empties.
//            Optional RUN timeout: define SUBCORE_DISPATCH_TIMEOUT_EN.
// Ports    : clk  - clock
//            rstn - asynchronous active-low reset
//            bus  - subcore_dispatcher_if.slave (fork command, launch
//                   outputs, end pulses, busy/join/spurious status)
// Revision : 1.0 - initial release
// ============================================================================
module subcore_dispatcher
    import inst_package::*;
#(
    parameter int N              = SUBCORE_NUM,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  wire logic            clk,
    input  wire logic            rstn,
    subcore_dispatcher_if.slave  bus
);
    localparam logic [1:0] c_ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] c_ST_LAUNCH = 2'(LAUNCH);
    localparam logic [1:0] c_ST_RUN    = 2'(RUN);

    logic [1:0]   r_state;
    logic [N-1:0] r_busy;
    logic [N-1:0] r_exec;
    logic [31:0]  r_req_pc [N];
    logic         r_join;
    logic         r_join_to;
    logic         r_spur;

    logic [N-1:0] w_ended;
    logic [N-1:0] w_busy_next;
    logic         w_expired;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lanes
            assign w_ended[gi]               = bus.subcore_ended[gi];
            assign bus.exec_requested[gi]    = r_exec[gi];
            assign bus.requested_pc[gi]      = r_req_pc[gi];
        end
    endgenerate

    assign w_busy_next = r_busy & ~w_ended;

`ifdef SUBCORE_DISPATCH_TIMEOUT_EN
    dispatch_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rstn      (rstn),
        .i_run     (r_state == c_ST_RUN),
        .o_expired (w_expired)
    );
`else
    // No timer in this build: folds to constant 0 while keeping the
    // parameter referenced so the interface stays identical.
    assign w_expired = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= c_ST_IDLE;
            r_busy    <= '0;
            r_exec    <= '0;
            r_join    <= 1'b0;
            r_join_to <= 1'b0;
            r_spur    <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_req_pc[i] <= '0;
            end
        end else begin
            r_exec    <= '0;
            r_join    <= 1'b0;
            r_join_to <= 1'b0;

            // An end pulse from a core not currently busy is only recorded.
            if (|(w_ended & ~r_busy)) begin
                r_spur <= 1'b1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (bus.fork_valid) begin
                        r_busy <= bus.fork_mask;
                        // PCs are loaded at acceptance so they are valid in
                        // the LAUNCH cycle together with exec_requested.
                        for (int i = 0; i < N; i++) begin
                            if (bus.fork_mask[i]) begin
                                r_req_pc[i] <= bus.fork_pc;
                            end
                        end
                        if (|bus.fork_mask) begin
                            r_exec  <= bus.fork_mask;
                            r_state <= c_ST_LAUNCH;
                        end else begin
                            r_join  <= 1'b1;
                        end
                    end
                end
                c_ST_LAUNCH, c_ST_RUN: begin
                    // Normal completion wins over a coincident expiry.
                    if (w_busy_next == '0) begin
                        r_busy  <= '0;
                        r_join  <= 1'b1;
                        r_state <= c_ST_IDLE;
                    end else if (w_expired) begin
                        r_busy    <= '0;
                        r_join    <= 1'b1;
                        r_join_to <= 1'b1;
                        r_state   <= c_ST_IDLE;
                    end else begin
                        r_busy  <= w_busy_next;
                        r_state <= c_ST_RUN;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.fork_ready   = (r_state == c_ST_IDLE);
    assign bus.busy_mask    = r_busy;
    assign bus.join_done    = r_join;
    assign bus.join_timeout = r_join_to;
    assign bus.spurious_end = r_spur;

endmodule : subcore_dispatcher
`default_nettype wire

// File: doc/subcore_dispatcher.md
# subcore_dispatcher

Main-core-side fork/join controller for the subcore array. It accepts a fork command carrying a start PC and a subcore mask, then issues a one-cycle execution request to each selected subcore. It tracks which launched subcores are still running and reports join completion once every launched subcore has ended. It sits between the main core's fork/join instructions and the `exec_requested` / `requested_pc` / `subcore_ended` wires that run to the `sub` instances.

## Interface
- `N`, default `SUBCORE_NUM` (8): number of subcores served.
- `TIMEOUT_CYCLES`, default 65535: RUN-state cycle limit; used only with the timeout feature.
- `clk`  in  1  clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `fork_valid`  in  1  fork command present.
- `fork_ready`  out  1  dispatcher can accept a fork.
- `fork_pc`  in  32  start PC for the launched subcores.
- `fork_mask`  in  N  bit i set = launch subcore i.
- `subcore_ended[0:N-1]`  in  1 each  one-cycle pulse when subcore i finishes.
- `exec_requested[0:N-1]`  out  1 each  one-cycle launch pulse to subcore i.
- `requested_pc[0:N-1]`  out  32 each  start PC for subcore i.
- `busy_mask`  out  N  launched subcores that have not yet ended.
- `join_done`  out  1  one-cycle pulse when the fork group completes.
- `join_timeout`  out  1  qualifies `join_done`: the group was abandoned on timeout.
- `spurious_end`  out  1  sticky flag: an end pulse arrived from a subcore that was not busy.

## Operation
- States are IDLE, LAUNCH and RUN.
- `fork_ready` = (state == IDLE).
- **IDLE, on `fork_valid && fork_ready`:**
  - Latch `fork_pc`.
  - `busy_mask <= fork_mask`.
  - Nonzero mask: go to LAUNCH.
  - Zero mask: stay in IDLE and pulse `join_done` next cycle, with no launch.
- **LAUNCH (exactly 1 cycle):**
  - `exec_requested[i] = mask[i]`.
  - Every `requested_pc[i]` with `mask[i]` set is loaded with the latched PC.
  - Next state is RUN.
- **RUN, every cycle:** `busy_mask <= busy_mask & ~ended_vec`. When the result is zero, go to IDLE and pulse `join_done` with `join_timeout` = 0.
- **End-pulse handling in any state:**
  - An `ended[i]` with `busy_mask[i]` = 0 sets `spurious_end` and is otherwise ignored.
  - An `ended[i]` on a busy core during LAUNCH clears its bit normally.
- `requested_pc[i]` holds its value until the next launch of core i. Unselected cores keep their old PC.
- `fork_valid` outside IDLE is ignored: not accepted, no side effects.
- Reset mid-operation:
  - All state is cleared immediately.
  - Pending launches are dropped.
  - No `join_done` is issued for the interrupted group.

## Timing
- Reset values:
  - state = IDLE, so `fork_ready` = 1.
  - `exec_requested` all 0.
  - `requested_pc` all 0.
  - `busy_mask` = 0.
  - `join_done`, `join_timeout` and `spurious_end` = 0.
- Fork accepted at edge T:
  - `exec_requested` is high for cycle T+1 only.
  - `requested_pc` is valid from T+1.
  - `busy_mask` shows the new mask from T+1.
- An end pulse sampled at edge E clears its busy bit in cycle E+1.
- If that was the last busy bit:
  - `join_done` is high in cycle E+1.
  - `fork_ready` is high in E+1, so a new fork is accepted at edge E+1.
- Simultaneous end pulses from several cores are all cleared in the same cycle.
- Minimum fork-to-join latency is 2 cycles after acceptance: every core ends in the LAUNCH cycle.
- Zero-mask fork accepted at T: `join_done` in T+1.

## Configuration
- Macro: `SUBCORE_DISPATCH_TIMEOUT_EN`.
- **Defined:**
  - A 32-bit counter clears on entry to RUN and increments each RUN cycle.
  - When the counter equals `TIMEOUT_CYCLES - 1` and `busy_mask` is still nonzero:
    - Go to IDLE.
    - `join_done` = 1 and `join_timeout` = 1 for one cycle.
    - `busy_mask` clears.
  - Later end pulses from abandoned cores set `spurious_end`.
- **Undefined:** no counter, `join_timeout` is tied to 0, and RUN waits indefinitely.

## Structure
- The shared package (`inst_package`) holds `SUBCORE_NUM` and the `dispatch_state_t` enum {IDLE, LAUNCH, RUN}.
- One sub-module, `dispatch_timer`, holds the RUN-cycle counter and its expiry compare. It is instantiated only under the macro.

## Test plan
- Reset, then fork `mask`=0x05, `pc`=0x100:
  - `exec_requested[0]` and `[2]` pulse one cycle after acceptance.
  - `requested_pc[0]` = `requested_pc[2]` = 0x100.
  - `busy_mask` = 0x05.
- Same group, end[2] then, 3 cycles later, end[0]:
  - `busy_mask` = 0x01, then 0x00.
  - `join_done` is high exactly one cycle, the cycle after end[0].
  - `fork_ready` is high in that same cycle.
- Fork `mask`=0xFF, then all 8 `ended` pulse in the same cycle: single `join_done` next cycle, `busy_mask` = 0.
- End[3] in IDLE, and end[1] while only core 0 is busy: `spurious_end` = 1 and stays 1; `busy_mask` is unchanged.
- Fork `mask`=0x00: no `exec_requested` pulses; `join_done` in the next cycle.
- With the macro defined and `TIMEOUT_CYCLES`=16, fork `mask`=0x02 with no end pulse:
  - `join_done` and `join_timeout` go high 16 cycles after RUN entry.
  - `busy_mask` = 0.
  - A later end[1] sets `spurious_end`.
